stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-channel, WIDTH-bit registered stream multiplexer, the sequential successor to the combinational 4-to-1 mux used in the RISC-V datapath. Each input channel has a valid/ready handshake. One channel is granted per cycle, either by an explicit select (fixed mode) or by a rotating round-robin pointer (RR mode). The granted beat is captured into a single output register with its own valid/ready handshake. The block sits between multiple producers (e.g. writeback sources, bus masters) and one consumer.

## Interface
Parameters:
- WIDTH, 8, data bits per channel
- N, 4, number of input channels (≥2, need not be a power of two)
- SELW, $clog2(N), width of select/channel-index fields

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SELW  channel select, used only when mode=0
- in_data  input  N*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready (combinational)
- out_data  output  WIDTH  registered data
- out_ch  output  SELW  index of the channel that supplied out_data
- out_valid  output  1  output register holds a beat
- out_ready  input  1  consumer accepts the beat

## Operation
- load = !out_valid || out_ready. The output register may take a new beat when it is empty or is being drained in the same cycle.
- Grant, combinational:
  - mode=0: granted channel g = sel, grant valid iff sel < N and in_valid[sel].
  - mode=1: scan ptr, ptr+1, …, wrapping modulo N. g = first channel with in_valid set. Grant valid iff any in_valid bit is set.
- in_ready[i] = !rst && load && grant_valid && (g == i). At most one bit is set. No other channel sees ready.
- Clock edge with rst=1: out_valid=0, out_data=0, out_ch=0, ptr=0.
- Clock edge with load && grant_valid: out_data ← channel g data, out_ch ← g, out_valid ← 1. In mode=1 only, ptr ← (g==N-1) ? 0 : g+1.
- Clock edge with load && !grant_valid: out_valid ← 0. out_data and out_ch hold their values.
- Clock edge with !load (out_valid=1, out_ready=0): everything holds. This covers the output stall case.
- ptr is unchanged while mode=0. Switching modes is legal on any cycle, and the new mode applies to the grant in that same cycle.
- Input data is sampled only on a handshake (in_valid[g] && in_ready[g]). Producers must hold data and valid until they are granted.

## Timing
- Latency: 1 cycle. A beat accepted on edge k appears on out_data/out_valid after edge k.
- Throughput: 1 beat per cycle when out_ready stays high.
- Stall: out_valid=1 and out_ready=0 forces all in_ready=0 in that cycle, and out_data is stable.
- Simultaneous drain and fill (out_valid=1, out_ready=1, grant valid): the new beat replaces the old one with no bubble.
- RR fairness: with all N channels valid continuously and out_ready=1, grants run ptr, ptr+1, …, wrap. Each channel is granted once every N cycles.
- Wrap-around: after channel N-1 is granted, ptr=0. This also holds for non-power-of-two N; ptr never reaches N.
- Reset asserted mid-transfer: the output beat is discarded (out_valid=0 after the edge) and in_ready=0 during the reset cycle, so no input beat is consumed.
- Out-of-range sel (N not a power of two, mode=0): no grant, all in_ready=0.

## Test plan
- Reset values: WIDTH=8, N=4. Assert rst for 2 cycles with all in_valid=1 -> in_ready=0000 throughout; after the edge out_valid=0, out_data=0x00, out_ch=0.
- Fixed-select sweep: mode=0, in_data = {0x44,0x33,0x22,0x11}, in_valid=1111, out_ready=1, sel=0..3 on consecutive cycles -> one cycle later out_data=0x11,0x22,0x33,0x44 with out_ch=0..3; in_ready equals the one-hot of sel each cycle.
- Round-robin rotation: mode=1, in_valid=1111, out_ready=1 for 8 cycles from reset -> out_ch sequence 0,1,2,3,0,1,2,3 with no bubbles.
- RR skip and wrap: mode=1, ptr=3, in_valid=0101 -> channel 0 granted and ptr=1; next cycle channel 2 is granted and ptr=3.
- Backpressure: a beat 0x22 from channel 1 is in the output register, out_ready=0 for 3 cycles -> out_data=0x22 and out_valid=1 hold, in_ready=0000. Then raise out_ready with channel 3 valid -> out_data=0x44 on the next edge with no gap.
- Non-power-of-two: N=3, mode=0, sel=3, in_valid=111 -> in_ready=000 and out_valid falls to 0. In mode=1, grants cycle 0,1,2,0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer with valid/ready handshakes.
// One channel is granted per cycle, by explicit select or by a rotating round-robin pointer.
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_ch,
  output logic               out_valid,
  input  logic               out_ready
);

  logic             load;
  logic             grant_valid;
  logic [SELW-1:0]  grant_ch;
  logic [WIDTH-1:0] grant_data;

  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;

  assign load = !out_valid_q || out_ready;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_ch    = '0;
    idx         = 0;
    if (!mode) begin
      grant_ch = sel;
      for (int i = 0; i < N; i++) begin
        if (int'(sel) == i && in_valid[i]) grant_valid = 1'b1;
      end
    end else begin
      // Scan from the far end so the channel closest to ptr is the last (winning) write.
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(ptr_q) + k;
        if (idx >= N) idx = idx - N;
        if (in_valid[idx]) begin
          grant_valid = 1'b1;
          grant_ch    = SELW'(idx);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(grant_ch) == i) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = !rst && load && grant_valid;
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_valid_d = grant_valid;
      if (grant_valid) begin
        out_data_d = grant_data;
        out_ch_d   = grant_ch;
        if (mode) ptr_d = (int'(grant_ch) == N - 1) ? '0 : grant_ch + SELW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed vector table, N=3 corner sequence,
// and randomized traffic compared against a behavioural model.
module tb_stream_mux_rr;

  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 2;

  typedef struct {
    logic       rst;
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       oready;
    logic [3:0] exp_ir;
    logic       exp_ov;
    logic [7:0] exp_d;
    logic [1:0] exp_ch;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, mode, out_ready, out_valid;
  logic [S-1:0]   sel, out_ch;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic [W-1:0]   out_data;

  logic         rst3, mode3, out_ready3, out_valid3;
  logic [1:0]   sel3, out_ch3;
  logic [23:0]  in_data3;
  logic [2:0]   in_valid3, in_ready3;
  logic [7:0]   out_data3;

  stream_mux_rr #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(8), .N(3)) dut3 (
    .clk(clk), .rst(rst3), .mode(mode3), .sel(sel3), .in_data(in_data3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic r, logic m, logic [1:0] s, logic [3:0] v, logic o,
                              logic [3:0] ir, logic ov, logic [7:0] d, logic [1:0] ch);
    vec_t x;
    x.rst = r; x.mode = m; x.sel = s; x.valid = v; x.oready = o;
    x.exp_ir = ir; x.exp_ov = ov; x.exp_d = d; x.exp_ch = ch;
    return x;
  endfunction

  vec_t vecs[$];

  // Behavioural reference state for the random phase.
  int         m_ptr;
  logic       m_ov;
  logic [7:0] m_d;
  logic [1:0] m_ch;

  initial begin
    logic [7:0] exp_ch3 [4];
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b1;
    in_data = 32'h4433_2211;
    rst3 = 1'b1; mode3 = 1'b0; sel3 = '0; in_valid3 = '0; out_ready3 = 1'b1;
    in_data3 = 24'hCC_BB_AA;

    // Reset with every channel valid
    vecs.push_back(mk(1, 0, 0, 4'b1111, 1, 4'b0000, 0, 8'h00, 0));
    vecs.push_back(mk(1, 0, 0, 4'b1111, 1, 4'b0000, 0, 8'h00, 0));
    // Fixed-select sweep
    vecs.push_back(mk(0, 0, 0, 4'b1111, 1, 4'b0001, 1, 8'h11, 0));
    vecs.push_back(mk(0, 0, 1, 4'b1111, 1, 4'b0010, 1, 8'h22, 1));
    vecs.push_back(mk(0, 0, 2, 4'b1111, 1, 4'b0100, 1, 8'h33, 2));
    vecs.push_back(mk(0, 0, 3, 4'b1111, 1, 4'b1000, 1, 8'h44, 3));
    // Round-robin rotation from reset, two full laps
    vecs.push_back(mk(1, 1, 0, 4'b1111, 1, 4'b0000, 0, 8'h00, 0));
    for (int lap = 0; lap < 2; lap++) begin
      for (int c = 0; c < 4; c++) begin
        vecs.push_back(mk(0, 1, 0, 4'b1111, 1, 4'(1 << c), 1, 8'((c + 1) * 8'h11), 2'(c)));
      end
    end
    // Skip and wrap: ch2 only leaves ptr=3, then 0101 grants 0 then 2
    vecs.push_back(mk(0, 1, 0, 4'b0100, 1, 4'b0100, 1, 8'h33, 2));
    vecs.push_back(mk(0, 1, 0, 4'b0101, 1, 4'b0001, 1, 8'h11, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0101, 1, 4'b0100, 1, 8'h33, 2));
    // Backpressure: hold 0x22 for 3 cycles, then drain-and-fill from ch3
    vecs.push_back(mk(0, 0, 1, 4'b1111, 1, 4'b0010, 1, 8'h22, 1));
    for (int c = 0; c < 3; c++) vecs.push_back(mk(0, 0, 3, 4'b1000, 0, 4'b0000, 1, 8'h22, 1));
    vecs.push_back(mk(0, 0, 3, 4'b1000, 1, 4'b1000, 1, 8'h44, 3));
    // Empty grant drops valid, data/ch hold; fixed mode left ptr at 3
    vecs.push_back(mk(0, 0, 3, 4'b0000, 1, 4'b0000, 0, 8'h44, 3));
    vecs.push_back(mk(0, 1, 0, 4'b0000, 1, 4'b0000, 0, 8'h44, 3));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 1, 4'b1000, 1, 8'h44, 3));
    // Stall, then reset mid-transfer
    vecs.push_back(mk(0, 1, 0, 4'b1111, 0, 4'b0000, 1, 8'h44, 3));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 0, 4'b0000, 0, 8'h00, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; mode = vecs[i].mode; sel = vecs[i].sel;
      in_valid = vecs[i].valid; out_ready = vecs[i].oready;
      #1;
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
      tick();
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_d));
      check($sformatf("vec%0d out_ch", i), 32'(out_ch), 32'(vecs[i].exp_ch));
    end

    // Non-power-of-two N=3: out-of-range select, then RR wrap 0,1,2,0
    tick();
    rst3 = 1'b0; mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b111;
    #1;
    check("n3 sel0 in_ready", 32'(in_ready3), 32'b001);
    tick();
    check("n3 sel0 out_valid", 32'(out_valid3), 32'd1);
    check("n3 sel0 out_data", 32'(out_data3), 32'hAA);
    sel3 = 2'd3;
    #1;
    check("n3 sel3 in_ready", 32'(in_ready3), 32'b000);
    tick();
    check("n3 sel3 out_valid", 32'(out_valid3), 32'd0);
    mode3 = 1'b1;
    exp_ch3 = '{8'd0, 8'd1, 8'd2, 8'd0};
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("n3 rr%0d in_ready", c), 32'(in_ready3), 32'(3'b001 << exp_ch3[c]));
      tick();
      check($sformatf("n3 rr%0d out_ch", c), 32'(out_ch3), 32'(exp_ch3[c]));
      check($sformatf("n3 rr%0d out_data", c), 32'(out_data3), 32'(in_data3[exp_ch3[c]*8 +: 8]));
    end

    // Randomized traffic against the behavioural model
    m_ptr = 0; m_ov = 1'b0; m_d = '0; m_ch = '0;
    for (int c = 0; c < 400; c++) begin
      logic       load, gv;
      int         g;
      logic [3:0] exp_ir;
      rst       = (c == 0) || ($urandom_range(0, 31) == 0);
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;

      load = !m_ov || out_ready;
      gv   = 1'b0;
      g    = 0;
      if (!mode) begin
        g  = int'(sel);
        gv = in_valid[g];
      end else begin
        for (int k = 0; k < N && !gv; k++) begin
          if (in_valid[(m_ptr + k) % N]) begin
            gv = 1'b1;
            g  = (m_ptr + k) % N;
          end
        end
      end
      exp_ir = (!rst && load && gv) ? 4'(1 << g) : 4'b0000;
      #1;
      check($sformatf("rnd%0d in_ready", c), 32'(in_ready), 32'(exp_ir));

      if (rst) begin
        m_ptr = 0; m_ov = 1'b0; m_d = '0; m_ch = '0;
      end else if (load) begin
        m_ov = gv;
        if (gv) begin
          m_d  = in_data[g*8 +: 8];
          m_ch = 2'(g);
          if (mode) m_ptr = (g + 1) % N;
        end
      end
      tick();
      check($sformatf("rnd%0d out_valid", c), 32'(out_valid), 32'(m_ov));
      check($sformatf("rnd%0d out_data", c), 32'(out_data), 32'(m_d));
      check($sformatf("rnd%0d out_ch", c), 32'(out_ch), 32'(m_ch));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
